// File: rtl/giocatori_morra_pkg.sv
// morra_pkg: move/result encodings, manche floor and FSM states shared by the morra players
package morra_pkg;

    typedef enum logic [1:0] {
        MOVE_NONE = 2'b00,
        MOVE_A    = 2'b01,
        MOVE_B    = 2'b10,
        MOVE_C    = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        MANCHE_INVALID = 2'b00,
        MANCHE_P1      = 2'b01,
        MANCHE_P2      = 2'b10,
        MANCHE_TIE     = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        PARTITA_RUN = 2'b00,
        PARTITA_P1  = 2'b01,
        PARTITA_P2  = 2'b10,
        PARTITA_TIE = 2'b11
    } partita_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_PLAY,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [4:0] MIN_MANCHE = 5'd4;

    // Next move in the cycle 01 -> 10 -> 11 -> 01
    function automatic logic [1:0] rotate_move(input logic [1:0] m);
        return m == MOVE_A ? MOVE_B : m == MOVE_B ? MOVE_C : MOVE_A;
    endfunction

endpackage

// File: rtl/giocatori_morra_if.sv
// giocatori_morra_if: host/judge side signals of the morra player pair
interface giocatori_morra_if;

    logic       START;
    logic [3:0] CFG;
    logic       ACK;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic       INIZIA;
    logic       BUSY;
    logic       DONE;
    logic [1:0] RISULTATO;
    logic [3:0] VITTORIE1;
    logic [3:0] VITTORIE2;
    logic [4:0] PAREGGI;
    logic       ERRORE;

    modport master (
        output START, CFG, ACK, MANCHE, PARTITA,
        input  PRIMO, SECONDO, INIZIA, BUSY, DONE, RISULTATO,
               VITTORIE1, VITTORIE2, PAREGGI, ERRORE
    );

    modport slave (
        input  START, CFG, ACK, MANCHE, PARTITA,
        output PRIMO, SECONDO, INIZIA, BUSY, DONE, RISULTATO,
               VITTORIE1, VITTORIE2, PAREGGI, ERRORE
    );

endinterface

// File: rtl/giocatori_morra_mossa_lfsr.sv
// mossa_lfsr: one player's move source, an 8-bit LFSR with the repeat-winning-move ban
module mossa_lfsr
    import morra_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [1:0] forbid,
    output logic [1:0] move
);

    logic [7:0] lfsr;
    logic [1:0] cand;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per played move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED;
        else if (step)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // forbid is MOVE_NONE unless this player won last; a candidate is never 00 so no extra gating
    always_comb begin
        cand = lfsr[1:0] == MOVE_NONE ? MOVE_A : lfsr[1:0];
        move = cand == forbid ? rotate_move(cand) : cand;
    end

endmodule

// File: rtl/giocatori_morra.sv
// giocatori_morra: two LFSR morra players sequencing a match against an external judge
module giocatori_morra
    import morra_pkg::*;
#(
    parameter logic [7:0] SEED1 = 8'hA5,
    parameter logic [7:0] SEED2 = 8'h3C
) (
    input logic              clk,
    input logic              rst_n,
    giocatori_morra_if.slave bus
);

    state_t     state;
    logic [4:0] max_q;
    logic [5:0] played;
    logic [1:0] mv1;
    logic [1:0] mv2;
    logic [1:0] rec_win;
    logic [1:0] rec_mv;
    logic [1:0] win_nxt;
    logic [1:0] mv_nxt;
    logic [1:0] forbid1;
    logic [1:0] forbid2;
    logic [1:0] move1;
    logic [1:0] move2;
    logic [5:0] played_nxt;
    logic       sample;
    logic       counted;
    logic       over;
    logic       step;

    // The record seen by the next move already includes the manche being sampled now
    always_comb begin
        sample     = state == S_WAIT && !bus.START;
        win_nxt    = sample && bus.MANCHE == MANCHE_P1 ? WIN_P1 :
                     sample && bus.MANCHE == MANCHE_P2 ? WIN_P2 : rec_win;
        mv_nxt     = sample && bus.MANCHE == MANCHE_P1 ? mv1 :
                     sample && bus.MANCHE == MANCHE_P2 ? mv2 : rec_mv;
        forbid1    = win_nxt == WIN_P1 ? mv_nxt : MOVE_NONE;
        forbid2    = win_nxt == WIN_P2 ? mv_nxt : MOVE_NONE;
        counted    = bus.MANCHE != MANCHE_INVALID;
        played_nxt = played + {5'd0, counted};
        over       = played_nxt > {1'b0, max_q};
        step       = !bus.START && (state == S_CONFIG ||
                     (state == S_WAIT && bus.PARTITA == PARTITA_RUN && !over));
    end

    mossa_lfsr #(.SEED(SEED1)) u_primo (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .forbid (forbid1),
        .move   (move1)
    );

    mossa_lfsr #(.SEED(SEED2)) u_secondo (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .forbid (forbid2),
        .move   (move2)
    );

    // Match FSM with registered outputs; START restarts from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            max_q         <= '0;
            played        <= '0;
            mv1           <= '0;
            mv2           <= '0;
            rec_win       <= WIN_NONE;
            rec_mv        <= MOVE_NONE;
            bus.PRIMO     <= '0;
            bus.SECONDO   <= '0;
            bus.INIZIA    <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.RISULTATO <= '0;
            bus.VITTORIE1 <= '0;
            bus.VITTORIE2 <= '0;
            bus.PAREGGI   <= '0;
            bus.ERRORE    <= 1'b0;
        end else if (bus.START) begin
            state         <= S_CONFIG;
            max_q         <= MIN_MANCHE + {1'b0, bus.CFG};
            played        <= '0;
            rec_win       <= WIN_NONE;
            rec_mv        <= MOVE_NONE;
            bus.PRIMO     <= bus.CFG[3:2];
            bus.SECONDO   <= bus.CFG[1:0];
            bus.INIZIA    <= 1'b1;
            bus.BUSY      <= 1'b1;
            bus.DONE      <= 1'b0;
            bus.RISULTATO <= '0;
            bus.VITTORIE1 <= '0;
            bus.VITTORIE2 <= '0;
            bus.PAREGGI   <= '0;
            bus.ERRORE    <= 1'b0;
        end else begin
            case (state)
                S_CONFIG: begin
                    state       <= S_PLAY;
                    bus.INIZIA  <= 1'b0;
                    bus.PRIMO   <= move1;
                    bus.SECONDO <= move2;
                    mv1         <= move1;
                    mv2         <= move2;
                end
                S_PLAY: begin
                    state       <= S_WAIT;
                    bus.PRIMO   <= MOVE_NONE;
                    bus.SECONDO <= MOVE_NONE;
                end
                S_WAIT: begin
                    rec_win       <= win_nxt;
                    rec_mv        <= mv_nxt;
                    played        <= played_nxt;
                    bus.VITTORIE1 <= bus.MANCHE == MANCHE_P1 && bus.VITTORIE1 != 4'hF ?
                                     bus.VITTORIE1 + 4'd1 : bus.VITTORIE1;
                    bus.VITTORIE2 <= bus.MANCHE == MANCHE_P2 && bus.VITTORIE2 != 4'hF ?
                                     bus.VITTORIE2 + 4'd1 : bus.VITTORIE2;
                    bus.PAREGGI   <= bus.MANCHE == MANCHE_TIE && bus.PAREGGI != 5'h1F ?
                                     bus.PAREGGI + 5'd1 : bus.PAREGGI;
                    if (bus.PARTITA != PARTITA_RUN) begin
                        state         <= S_DONE;
                        bus.RISULTATO <= bus.PARTITA;
                        bus.BUSY      <= 1'b0;
                        bus.DONE      <= 1'b1;
                    end else if (over) begin
                        state         <= S_DONE;
                        bus.RISULTATO <= PARTITA_RUN;
                        bus.ERRORE    <= 1'b1;
                        bus.BUSY      <= 1'b0;
                        bus.DONE      <= 1'b1;
                    end else begin
                        state       <= S_PLAY;
                        bus.PRIMO   <= move1;
                        bus.SECONDO <= move2;
                        mv1         <= move1;
                        mv2         <= move2;
                    end
                end
                S_DONE: begin
                    if (bus.ACK) begin
                        state    <= S_IDLE;
                        bus.DONE <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_giocatori_morra.sv
// tb_giocatori_morra: directed and randomized matches checked against a rule-level player model
module tb_giocatori_morra;

    localparam logic [7:0] SEED1 = 8'hA5;
    localparam logic [7:0] SEED2 = 8'h3C;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    giocatori_morra_if bus();

    giocatori_morra #(.SEED1(SEED1), .SEED2(SEED2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model state: generators, winner record, tallies
    logic [7:0] l1, l2;
    int         rw;
    int         rm;
    int         v1, v2, pa, played, maxm, ris, err;
    int         e1, e2;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic int pick(input logic [7:0] l, input int who);
        int c;
        c = l % 4;
        if (c == 0) c = 1;
        if (who == rw && c == rm) c = c % 3 + 1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        l1 = SEED1; l2 = SEED2; rw = 0; rm = 0;
        v1 = 0; v2 = 0; pa = 0; played = 0; maxm = 4; ris = 0; err = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_primo"}, 8'(bus.PRIMO), 0);
        check({tag, "_secondo"}, 8'(bus.SECONDO), 0);
        check({tag, "_inizia"}, 8'(bus.INIZIA), 0);
        check({tag, "_busy"}, 8'(bus.BUSY), 0);
        check({tag, "_done"}, 8'(bus.DONE), 0);
        check({tag, "_ris"}, 8'(bus.RISULTATO), 0);
        check({tag, "_v1"}, 8'(bus.VITTORIE1), 0);
        check({tag, "_v2"}, 8'(bus.VITTORIE2), 0);
        check({tag, "_par"}, 8'(bus.PAREGGI), 0);
        check({tag, "_err"}, 8'(bus.ERRORE), 0);
    endtask

    task automatic check_tally(input string tag);
        check({tag, "_v1"}, 8'(bus.VITTORIE1), 8'(v1));
        check({tag, "_v2"}, 8'(bus.VITTORIE2), 8'(v2));
        check({tag, "_par"}, 8'(bus.PAREGGI), 8'(pa));
    endtask

    task automatic do_start(input logic [3:0] cfg);
        bus.START = 1'b1;
        bus.CFG   = cfg;
        @(posedge clk); #1;
        bus.START = 1'b0;
        v1 = 0; v2 = 0; pa = 0; played = 0; rw = 0; rm = 0; ris = 0; err = 0;
        maxm = 4 + int'(cfg);
        check("cfg_inizia", 8'(bus.INIZIA), 1);
        check("cfg_busy", 8'(bus.BUSY), 1);
        check("cfg_done", 8'(bus.DONE), 0);
        check("cfg_primo", 8'(bus.PRIMO), 8'(cfg[3:2]));
        check("cfg_secondo", 8'(bus.SECONDO), 8'(cfg[1:0]));
        check("cfg_err", 8'(bus.ERRORE), 0);
        check_tally("cfg");
        @(posedge clk); #1;
        check("play_inizia", 8'(bus.INIZIA), 0);
    endtask

    // Called while the DUT is in PLAY; returns in WAIT
    task automatic enter_wait();
        e1 = pick(l1, 1);
        e2 = pick(l2, 2);
        l1 = lstep(l1);
        l2 = lstep(l2);
        check("move_primo", 8'(bus.PRIMO), 8'(e1));
        check("move_secondo", 8'(bus.SECONDO), 8'(e2));
        if (rw == 1) check("norepeat1", 8'(bus.PRIMO == 2'(rm)), 0);
        if (rw == 2) check("norepeat2", 8'(bus.SECONDO == 2'(rm)), 0);
        check("play_busy", 8'(bus.BUSY), 1);
        bus.ACK = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.ACK = 1'b0;
        check("wait_primo", 8'(bus.PRIMO), 0);
        check("wait_secondo", 8'(bus.SECONDO), 0);
        check("wait_busy", 8'(bus.BUSY), 1);
    endtask

    task automatic play_round(input logic [1:0] manche, input logic [1:0] partita, output bit fin);
        enter_wait();
        bus.MANCHE  = manche;
        bus.PARTITA = partita;
        @(posedge clk); #1;
        if (manche == 2'b01) begin v1 = v1 < 15 ? v1 + 1 : 15; rw = 1; rm = e1; end
        if (manche == 2'b10) begin v2 = v2 < 15 ? v2 + 1 : 15; rw = 2; rm = e2; end
        if (manche == 2'b11) pa = pa < 31 ? pa + 1 : 31;
        if (manche != 2'b00) played++;
        fin = 1'b1;
        if (partita != 2'b00) ris = int'(partita);
        else if (played > maxm) begin err = 1; ris = 0; end
        else fin = 1'b0;
        check_tally("round");
        check("round_done", 8'(bus.DONE), 8'(fin));
        check("round_busy", 8'(bus.BUSY), 8'(!fin));
        if (fin) begin
            check("round_ris", 8'(bus.RISULTATO), 8'(ris));
            check("round_err", 8'(bus.ERRORE), 8'(err));
        end
    endtask

    task automatic ack_done();
        bus.ACK = 1'b0;
        @(posedge clk); #1;
        check("done_hold", 8'(bus.DONE), 1);
        bus.ACK = 1'b1;
        @(posedge clk); #1;
        bus.ACK = 1'b0;
        check("ack_done", 8'(bus.DONE), 0);
        check("ack_busy", 8'(bus.BUSY), 0);
        check("ack_ris", 8'(bus.RISULTATO), 8'(ris));
        check_tally("ack");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fin;
        int n;
        logic [1:0] list_c [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10};
        bus.START = 1'b0; bus.CFG = '0; bus.ACK = 1'b0; bus.MANCHE = '0; bus.PARTITA = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", 8'(bus.BUSY), 0);

        // four P1 wins, P1 takes the match on the fourth
        do_start(4'h0);
        for (int i = 0; i < 4; i++) begin
            play_round(2'b01, i == 3 ? 2'b01 : 2'b00, fin);
            check("a_fin", 8'(fin), 8'(i == 3));
        end
        check("a_v1", 8'(bus.VITTORIE1), 4);
        check("a_ris", 8'(bus.RISULTATO), 1);
        ack_done();

        // five ties, tie declared on the fifth
        do_start(4'h1);
        for (int i = 0; i < 5; i++) play_round(2'b11, i == 4 ? 2'b11 : 2'b00, fin);
        check("b_par", 8'(bus.PAREGGI), 5);
        check("b_ris", 8'(bus.RISULTATO), 3);
        ack_done();

        // judge never closes the match: overrun after the fifth counted manche
        do_start(4'h0);
        n = 0;
        fin = 1'b0;
        while (!fin && n < 6) begin
            play_round(list_c[n], 2'b00, fin);
            n++;
        end
        check("c_rounds", 8'(n), 6);
        check("c_err", 8'(bus.ERRORE), 1);
        check("c_done", 8'(bus.DONE), 1);
        check("c_ris", 8'(bus.RISULTATO), 0);
        ack_done();

        // abort from WAIT with a new config, then reset during PLAY
        do_start(4'h2);
        play_round(2'b01, 2'b00, fin);
        enter_wait();
        bus.MANCHE = 2'b10;
        do_start(4'h5);
        play_round(2'b10, 2'b00, fin);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_busy", 8'(bus.BUSY), 0);
        check("post_reset_inizia", 8'(bus.INIZIA), 0);

        // randomized matches
        for (int m = 0; m < 8; m++) begin
            do_start(4'($urandom_range(0, 15)));
            n = 0;
            fin = 1'b0;
            while (!fin && n < 120) begin
                play_round(2'($urandom_range(0, 3)),
                           $urandom_range(0, 9) == 0 ? 2'($urandom_range(1, 3)) : 2'b00, fin);
                n++;
            end
            if (!fin) begin
                errors++;
                $display("FAIL rand_budget: match %0d still running after %0d rounds", m, n);
            end else begin
                ack_done();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/giocatori_morra.md
GIOCATORI_MORRA -- requirements
Module: giocatori_morra

Interface
REQ-001 SHALL have parameter SEED1, default 8'hA5, the LFSR seed for player 1 (nonzero).
REQ-002 SHALL have parameter SEED2, default 8'h3C, the LFSR seed for player 2 (nonzero).
REQ-003 SHALL use one clock and asynchronous active-low reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous reset, active low.
REQ-006 SHALL have port START, input, 1, one-cycle request to begin a match.
REQ-007 SHALL have port CFG, input, 4, extra manche; max manche = 4 + CFG.
REQ-008 SHALL have port ACK, input, 1, host acknowledge of the result.
REQ-009 SHALL have port MANCHE, input, 2, judge round result: 00 invalid, 01 P1, 10 P2, 11 tie.
REQ-010 SHALL have port PARTITA, input, 2, judge match result: 00 running, 01 P1, 10 P2, 11 tie.
REQ-011 SHALL have port PRIMO, output, 2, player 1 move: 01, 10 or 11; 00 means no move.
REQ-012 SHALL have port SECONDO, output, 2, player 2 move, same encoding as PRIMO.
REQ-013 SHALL have port INIZIA, output, 1, judge configure/reset strobe.
REQ-014 SHALL have port BUSY, output, 1, high while a match is running.
REQ-015 SHALL have port DONE, output, 1, high while the result is held.
REQ-016 SHALL have port RISULTATO, output, 2, latched PARTITA.
REQ-017 SHALL have port VITTORIE1, output, 4, count of valid manche won by player 1.
REQ-018 SHALL have port VITTORIE2, output, 4, count of valid manche won by player 2.
REQ-019 SHALL have port PAREGGI, output, 5, count of tied manche.
REQ-020 SHALL have port ERRORE, output, 1, high if the judge overran the manche limit.

Function
REQ-021 SHALL implement the FSM states IDLE, CONFIG, PLAY, WAIT and DONE.
REQ-022 IDLE SHALL drive PRIMO=SECONDO=00 and INIZIA=0, and SHALL go to CONFIG on START=1.
REQ-023 CONFIG SHALL last 1 cycle with INIZIA=1 and {PRIMO,SECONDO}=CFG, then go to PLAY.
REQ-024 On entering CONFIG the block SHALL latch max=4+CFG (5 bits), clear all counters, clear ERRORE and clear the last-winner record.
REQ-025 PLAY SHALL last 1 cycle driving the two generated moves, then go to WAIT.
REQ-026 WAIT SHALL last 1 cycle driving 00/00, and SHALL sample MANCHE and PARTITA on the edge that leaves WAIT.
REQ-027 Latency from a move to its sample SHALL be exactly 2 edges.
REQ-028 On a sample with MANCHE=01, VITTORIE1 SHALL increment, last winner = P1 and last winning move = PRIMO.
REQ-029 On a sample with MANCHE=10, VITTORIE2 SHALL increment, last winner = P2 and last winning move = SECONDO.
REQ-030 On a sample with MANCHE=11, PAREGGI SHALL increment and the last-winner record SHALL be kept.
REQ-031 On a sample with MANCHE=00, no counter SHALL change and the move SHALL be regenerated (not counted).
REQ-032 On a sample with PARTITA≠00, RISULTATO SHALL latch PARTITA and the FSM SHALL go to DONE; otherwise it SHALL return to PLAY.
REQ-033 When the played count (VITTORIE1+VITTORIE2+PAREGGI) exceeds max with PARTITA=00, ERRORE SHALL set, RISULTATO SHALL be 00 and the FSM SHALL go to DONE.
REQ-034 DONE SHALL hold DONE=1 and drive moves 00, and SHALL go to IDLE on ACK=1.
REQ-035 BUSY SHALL be 1 in CONFIG, PLAY and WAIT.
REQ-036 Move generation SHALL take candidate = lfsr[1:0] and map 00 to 01.
REQ-037 If the candidate player is the last winner and the candidate equals the last winning move, the candidate SHALL rotate (01→10→11→01).
REQ-038 Each player's LFSR SHALL advance once per PLAY cycle.
REQ-039 The LFSRs SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1.
REQ-040 Counters SHALL saturate (4-bit at 15, 5-bit at 31) and SHALL never wrap.
REQ-041 START in any non-IDLE state SHALL abort the match and enter CONFIG on the next edge, with the new CFG; START has priority over ACK.
REQ-042 ACK outside DONE SHALL be ignored.

Reset
REQ-043 While rst_n=0, the FSM SHALL be in IDLE.
REQ-044 While rst_n=0, all outputs SHALL be 0 (PRIMO, SECONDO, RISULTATO, counters, INIZIA, BUSY, DONE, ERRORE).
REQ-045 While rst_n=0, the LFSRs SHALL hold SEED1 and SEED2, and the last-winner record SHALL be cleared.
REQ-046 Reset mid-match SHALL take effect immediately and asynchronously; resume SHALL be only via a new START.

Structure
REQ-047 Package morra_pkg SHALL hold the move encodings, the MANCHE/PARTITA codes, MIN_MANCHE=4 and the FSM state enum.
REQ-048 Sub-module mossa_lfsr SHALL contain the LFSR, the 00 mapping and the forbidden-move rotation, and SHALL be instantiated twice.

Verification
REQ-049 Reset, then START with CFG=0000 -> INIZIA high for 1 cycle with PRIMO=SECONDO=00, max=4, BUSY=1.
REQ-050 Judge model answering 01 for four manche with PARTITA=01 on the 4th -> VITTORIE1=4, RISULTATO=01, DONE=1; ACK -> IDLE.
REQ-051 After MANCHE=01 with PRIMO=10, force LFSR1 candidate 10 -> next PRIMO=11, never 10.
REQ-052 CFG=0001 with judge answering 11 for five manche and PARTITA=11 -> PAREGGI=5, RISULTATO=11.
REQ-053 Judge never asserts PARTITA with CFG=0000 -> after the 5th counted manche, ERRORE=1, DONE=1, RISULTATO=00.
REQ-054 START during WAIT, and rst_n=0 during PLAY -> CONFIG on the next edge with counters cleared; outputs 0 immediately on reset.
